// File: rtl/ula_pkg.sv
// Shared opcodes, FSM encoding and counter sizing for the sequential ALU and its BCD converter.
package ula_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_INV = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CONV = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic is_iter(input op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ula_seq_nbits_if.sv
// Request/result bundle of the sequential ALU; master issues operations, slave is the ALU.
interface ula_seq_nbits_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      A_in;
  logic [WIDTH-1:0]      B_in;
  logic                  Cin;
  logic [2:0]            OP_sel;
  logic                  busy;
  logic                  done;
  logic [2*WIDTH-1:0]    Result_out;
  logic                  Cout;
  logic                  OV;
  logic                  Z;
  logic                  ERR;
  logic                  NEG;
  logic [4*DIGITS-1:0]   BCD_out;

  modport master (
    output start, A_in, B_in, Cin, OP_sel,
    input  busy, done, Result_out, Cout, OV, Z, ERR, NEG, BCD_out
  );

  modport slave (
    input  start, A_in, B_in, Cin, OP_sel,
    output busy, done, Result_out, Cout, OV, Z, ERR, NEG, BCD_out
  );
endinterface

// File: rtl/bcd_dabble_seq.sv
// Sequential double-dabble: one load cycle then NBITS shift cycles; o_done flags the final shift,
// with o_bcd carrying the finished value in that same cycle. i_start is ignored while busy.
module bcd_dabble_seq
  import ula_pkg::*;
#(
  parameter int NBITS  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [NBITS-1:0]    i_bin,
  output logic                o_busy,
  output logic                o_done,
  output logic [4*DIGITS-1:0] o_bcd
);
  localparam int CW = cnt_w(NBITS);

  logic                r_run;
  logic [CW-1:0]       r_cnt;
  logic [NBITS-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_bcd;
  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_bcd_nxt;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
    w_bcd_nxt = {w_adj[4*DIGITS-2:0], r_bin[NBITS-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_bin <= '0;
      r_bcd <= '0;
    end else if (!r_run) begin
      if (i_start) begin
        r_run <= 1'b1;
        r_cnt <= CW'(NBITS);
        r_bin <= i_bin;
        r_bcd <= '0;
      end
    end else begin
      r_bcd <= w_bcd_nxt;
      r_bin <= {r_bin[NBITS-2:0], 1'b0};
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) r_run <= 1'b0;
    end
  end

  assign o_busy = r_run;
  assign o_done = r_run && (r_cnt == CW'(1));
  assign o_bcd  = w_bcd_nxt;

endmodule

// File: rtl/ula_seq_nbits.sv
// Sequential ALU: done 1+E+2*WIDTH cycles after accept (E=1, or WIDTH for mul/div), then BCD of result.
// No backpressure: start is taken only in IDLE, anything arriving while busy or in DONE is dropped.
module ula_seq_nbits
  import ula_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 5
) (
  input logic            clk,
  input logic            rst_n,
  ula_seq_nbits_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  localparam int RW = 2 * WIDTH;

  state_e              r_state, w_state_nxt;
  op_e                 r_op;
  logic [WIDTH-1:0]    r_a, r_b, r_hi, r_lo;
  logic                r_cin, r_c;
  logic [CW-1:0]       r_cnt;
  logic [RW-1:0]       r_res;
  logic                r_cout, r_ov, r_z, r_err, r_neg;
  logic [4*DIGITS-1:0] r_bcd;

  logic                w_accept, w_cv_start, w_cv_busy, w_cv_done, w_div_ge;
  logic [WIDTH:0]      w_alu, w_mul_sum, w_div_sh, w_div_sub;
  logic [WIDTH-1:0]    w_mag;
  logic [RW-1:0]       w_res, w_disp;
  logic                w_cout, w_ov, w_neg, w_err;
  logic [4*DIGITS-1:0] w_cv_bcd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_state_nxt = S_EXEC;
        w_accept    = 1'b1;
      end
      S_EXEC:  if (r_cnt == '0) w_state_nxt = S_CONV;
      S_CONV:  if (w_cv_done)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
      OP_SUB:  w_alu = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, r_cin};
      OP_AND:  w_alu = {1'b0, r_a & r_b};
      OP_OR:   w_alu = {1'b0, r_a | r_b};
      OP_XOR:  w_alu = {1'b0, r_a ^ r_b};
      default: w_alu = '0;
    endcase
  end

  // r_hi/r_lo double as {accumulator, multiplier} for mul and {remainder, dividend/quotient} for div.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_div_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge  = w_div_sh >= {1'b0, r_b};
  assign w_div_sub = w_div_sh - {1'b0, r_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
      r_op  <= OP_ADD;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_c   <= 1'b0;
    end else if (w_accept) begin
      r_a   <= bus.A_in;
      r_b   <= bus.B_in;
      r_cin <= bus.Cin;
      r_op  <= op_e'(bus.OP_sel);
      r_cnt <= is_iter(op_e'(bus.OP_sel)) ? CW'(WIDTH - 1) : '0;
      r_hi  <= '0;
      r_lo  <= (op_e'(bus.OP_sel) == OP_DIV) ? bus.A_in : bus.B_in;
      r_c   <= 1'b0;
    end else if (r_state == S_EXEC) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      case (r_op)
        OP_MUL: begin
          r_hi <= w_mul_sum[WIDTH:1];
          r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
        OP_DIV: begin
          r_hi <= w_div_ge ? w_div_sub[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
        end
        default: begin
          r_c  <= w_alu[WIDTH];
          r_lo <= w_alu[WIDTH-1:0];
        end
      endcase
    end
  end

  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_ov   = 1'b0;
    w_neg  = 1'b0;
    w_err  = 1'b0;
    w_mag  = '0 - r_lo;
    case (r_op)
      OP_ADD: begin
        w_res  = {{WIDTH{1'b0}}, r_lo};
        w_cout = r_c;
        w_ov   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (r_lo[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res  = {{WIDTH{1'b0}}, r_lo};
        w_cout = r_c;
        w_ov   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (r_lo[WIDTH-1] != r_a[WIDTH-1]);
        w_neg  = r_lo[WIDTH-1];
      end
      OP_AND, OP_OR, OP_XOR: w_res = {{WIDTH{1'b0}}, r_lo};
      OP_MUL: w_res = {r_hi, r_lo};
      OP_DIV: begin
        if (r_b == '0) w_err = 1'b1;
        else           w_res = {r_hi, r_lo};
      end
      default: w_err = 1'b1;
    endcase
    if (w_neg)                w_disp = {{WIDTH{1'b0}}, w_mag};
    else if (r_op == OP_DIV)  w_disp = {{WIDTH{1'b0}}, w_res[WIDTH-1:0]};
    else                      w_disp = w_res;
  end

  assign w_cv_start = (r_state == S_CONV) && !w_cv_busy;

  bcd_dabble_seq #(
    .NBITS  (RW),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_cv_start),
    .i_bin   (w_disp),
    .o_busy  (w_cv_busy),
    .o_done  (w_cv_done),
    .o_bcd   (w_cv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res  <= '0;
      r_cout <= 1'b0;
      r_ov   <= 1'b0;
      r_z    <= 1'b0;
      r_err  <= 1'b0;
      r_neg  <= 1'b0;
      r_bcd  <= '0;
    end else if ((r_state == S_CONV) && w_cv_done) begin
      r_res  <= w_res;
      r_cout <= w_cout;
      r_ov   <= w_ov;
      r_z    <= (w_res == '0);
      r_err  <= w_err;
      r_neg  <= w_neg;
      r_bcd  <= w_cv_bcd;
    end
  end

  assign bus.busy       = (r_state == S_EXEC) || (r_state == S_CONV);
  assign bus.done       = (r_state == S_DONE);
  assign bus.Result_out = r_res;
  assign bus.Cout       = r_cout;
  assign bus.OV         = r_ov;
  assign bus.Z          = r_z;
  assign bus.ERR        = r_err;
  assign bus.NEG        = r_neg;
  assign bus.BCD_out    = r_bcd;

endmodule

// File: tb/tb_ula_seq_nbits.sv
// Directed bench for ula_seq_nbits (WIDTH=8, DIGITS=5): arithmetic reference model plus literal pins.
module tb_ula_seq_nbits;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ula_seq_nbits_if #(.WIDTH(8), .DIGITS(5)) bus ();

  ula_seq_nbits #(.WIDTH(8), .DIGITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [40:0] outs();
    return {bus.Result_out, bus.Cout, bus.OV, bus.Z, bus.ERR, bus.NEG, bus.BCD_out};
  endfunction

  // Reference: {Result, Cout, OV, Z, ERR, NEG, BCD} straight from the arithmetic rules.
  function automatic logic [40:0] model(input int a, input int b, input int cin, input logic [2:0] op);
    int res, cout, ov, neg, err, s, disp;
    logic [19:0] bcd;
    res = 0; cout = 0; ov = 0; neg = 0; err = 0;
    case (op)
      3'd0: begin
        s = a + b + cin; res = s % 256; cout = (s > 255) ? 1 : 0;
        ov = (((a >= 128) == (b >= 128)) && ((res >= 128) != (a >= 128))) ? 1 : 0;
      end
      3'd1: begin
        s = a - b - cin; cout = (s < 0) ? 1 : 0; res = (s + 512) % 256;
        neg = (res >= 128) ? 1 : 0;
        ov = (((a >= 128) != (b >= 128)) && ((res >= 128) != (a >= 128))) ? 1 : 0;
      end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = a * b;
      3'd6: if (b == 0) err = 1; else res = (a % b) * 256 + a / b;
      default: err = 1;
    endcase
    if (neg == 1)       disp = 256 - res;
    else if (op == 3'd6) disp = res % 256;
    else                disp = res;
    bcd = '0;
    for (int d = 0; d < 5; d++) begin
      bcd[4*d +: 4] = 4'(disp % 10);
      disp = disp / 10;
    end
    return {16'(res), 1'(cout), 1'(ov), (res == 0), 1'(err), 1'(neg), bcd};
  endfunction

  int          m_left;
  logic        m_busy, m_done;
  logic [40:0] m_out, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_out <= '0; m_pend <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_out <= m_pend;
      end
      m_left <= m_left - 1;
    end else if (bus.start) begin
      m_busy <= 1'b1;
      m_left <= 1 + (((bus.OP_sel == 3'd5) || (bus.OP_sel == 3'd6)) ? 8 : 1) + 16;
      m_pend <= model(int'(bus.A_in), int'(bus.B_in), int'(bus.Cin), bus.OP_sel);
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy_done", {62'd0, bus.busy, bus.done}, {62'd0, m_busy, m_done});
    chk("cyc_outputs", 64'(outs()), 64'(m_out));
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [2:0] op, input int exp_lat, input int pulse_at, input string nm);
    int n;
    @(posedge clk); #1;
    bus.A_in = a; bus.B_in = b; bus.Cin = cin; bus.OP_sel = op; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A_in = 8'($urandom); bus.B_in = 8'($urandom);
    bus.Cin = 1'($urandom); bus.OP_sel = 3'($urandom);
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      bus.start = (n == pulse_at);
      if (bus.done) break;
    end
    bus.start = 1'b0;
    chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
  endtask

  initial begin
    int ndone;
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.A_in = '0; bus.B_in = '0; bus.Cin = 1'b0; bus.OP_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(outs()), 64'd0);
    chk("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    rst_n = 1'b1;

    run_op(8'd200, 8'd100, 1'b0, 3'd0, 18, 0, "add");
    chk("add_result", 64'(bus.Result_out), 64'h002C);
    chk("add_cout_ov", {62'd0, bus.Cout, bus.OV}, 64'd2);
    chk("add_bcd", 64'(bus.BCD_out), 64'h00044);

    run_op(8'd5, 8'd9, 1'b0, 3'd1, 18, 0, "sub");
    chk("sub_result", 64'(bus.Result_out), 64'h00FC);
    chk("sub_cout_neg", {62'd0, bus.Cout, bus.NEG}, 64'd3);
    chk("sub_bcd", 64'(bus.BCD_out), 64'h00004);

    run_op(8'd255, 8'd255, 1'b0, 3'd5, 25, 0, "mul");
    chk("mul_result", 64'(bus.Result_out), 64'hFE01);
    chk("mul_bcd", 64'(bus.BCD_out), 64'h65025);

    run_op(8'd200, 8'd7, 1'b0, 3'd6, 25, 0, "div");
    chk("div_result", 64'(bus.Result_out), 64'h041C);
    chk("div_bcd", 64'(bus.BCD_out), 64'h00028);

    run_op(8'd200, 8'd0, 1'b0, 3'd6, 25, 0, "div0");
    chk("div0_err_z", {62'd0, bus.ERR, bus.Z}, 64'd3);
    chk("div0_result", 64'(bus.Result_out), 64'd0);

    run_op(8'd12, 8'd34, 1'b1, 3'd7, 18, 0, "inv");
    chk("inv_err_z", {62'd0, bus.ERR, bus.Z}, 64'd3);
    chk("inv_result", 64'(bus.Result_out), 64'd0);

    run_op(8'd100, 8'd100, 1'b0, 3'd0, 18, 0, "add_ov");
    chk("add_ov_flag", {63'd0, bus.OV}, 64'd1);
    run_op(8'd0, 8'd255, 1'b1, 3'd1, 18, 0, "sub_cin");
    run_op(8'hF0, 8'h3C, 1'b0, 3'd2, 18, 0, "and");
    run_op(8'hF0, 8'h3C, 1'b0, 3'd3, 18, 0, "or");
    run_op(8'hAA, 8'hAA, 1'b0, 3'd4, 18, 0, "xor");
    chk("xor_zero", {63'd0, bus.Z}, 64'd1);
    run_op(8'd13, 8'd200, 1'b0, 3'd6, 25, 0, "div_small");

    run_op(8'd255, 8'd255, 1'b0, 3'd5, 25, 5, "mul_pulse");
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("mul_pulse_single_done", 64'(ndone), 64'd0);

    bus.A_in = 8'd255; bus.B_in = 8'd255; bus.OP_sel = 3'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", 64'(outs()), 64'd0);
    chk("arst_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(8'd17, 8'd25, 1'b0, 3'd0, 18, 0, "post_rst_add");
    chk("post_rst_result", 64'(bus.Result_out), 64'h002A);
    chk("post_rst_bcd", 64'(bus.BCD_out), 64'h00042);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_seq_nbits.md
ULA_SEQ_NBITS -- requirements
Module: ula_seq_nbits

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (min 4).
REQ-002 Parameter DIGITS, default 5, BCD digit count; SHALL satisfy 10^DIGITS > 2^(2*WIDTH).
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  operation request, sampled in IDLE only.
REQ-006 A_in, B_in  input  WIDTH each  unsigned operands.
REQ-007 Cin  input  1  carry-in for add, borrow-in for sub.
REQ-008 OP_sel  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 div, 111 invalid.
REQ-009 busy  output  1  high from the cycle after an accepted start until done is asserted.
REQ-010 done  output  1  one-cycle pulse, outputs valid.
REQ-011 Result_out  output  2*WIDTH  registered result.
REQ-012 Cout, OV, Z, ERR, NEG  output  1 each  registered flags.
REQ-013 BCD_out  output  4*DIGITS  packed BCD of display magnitude, digit 0 in bits [3:0].

Function
REQ-014 FSM states IDLE, EXEC, CONV, DONE; IDLE->EXEC on start; EXEC->CONV after E cycles; CONV->DONE after 2*WIDTH cycles; DONE->IDLE after 1 cycle.
REQ-015 A_in, B_in, Cin, OP_sel latched on the accepting edge; later input changes have no effect on the current operation.
REQ-016 start while busy or in DONE is ignored, not queued.
REQ-017 E = 1 for add/sub/and/or/xor/invalid; E = WIDTH for mul (shift-add) and div (restoring).
REQ-018 done asserted exactly 1+E+2*WIDTH cycles after the accepting edge.
REQ-019 All outputs except busy/done update atomically on the edge entering DONE and hold until the next DONE.
REQ-020 Add: low WIDTH bits = A+B+Cin, upper bits 0, Cout = carry out, OV = two's-complement overflow.
REQ-021 Sub: low WIDTH bits = A-B-Cin mod 2^WIDTH, upper bits 0, Cout = borrow, OV = two's-complement overflow, NEG = result MSB.
REQ-022 Logic ops: low WIDTH bits = bitwise result, upper bits 0, Cout=OV=NEG=0.
REQ-023 Mul: Result_out = full 2*WIDTH product, Cout=OV=NEG=0.
REQ-024 Div: Result_out = {remainder, quotient}; B_in=0 -> ERR=1, Result_out=0, iteration still takes WIDTH cycles.
REQ-025 Invalid op 111: ERR=1, Result_out=0, other flags 0.
REQ-026 ERR=0 for all other cases; Z = (Result_out == 0).
REQ-027 Display magnitude: NEG=1 -> two's complement of low WIDTH bits; div -> quotient only; otherwise Result_out; converted by sequential double-dabble, 2*WIDTH shift cycles.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE and busy, done, Result_out, flags and BCD_out to 0, including mid-operation.
REQ-029 First start after rst_n release is accepted normally; no partial state from an aborted operation persists.

Structure
REQ-030 Opcode constants, FSM state encoding and iteration-counter width function reside in shared package ula_pkg.
REQ-031 Double-dabble converter is sub-module bcd_dabble_seq (start/done handshake, parameters NBITS, DIGITS); mul/div datapath stays in the top.

Verification (WIDTH=8, DIGITS=5)
REQ-032 add A=200, B=100, Cin=0 -> Result_out=16'h002C, Cout=1, OV=0, BCD_out=20'h00044, done 18 cycles after start.
REQ-033 sub A=5, B=9, Cin=0 -> Result_out=16'h00FC, Cout=1, NEG=1, BCD_out=20'h00004.
REQ-034 mul A=255, B=255 -> Result_out=16'hFE01, BCD_out=20'h65025, done 25 cycles after start.
REQ-035 div A=200, B=7 -> Result_out=16'h041C, BCD_out=20'h00028; div B=0 -> ERR=1, Z=1, Result_out=0.
REQ-036 start pulsed during a mul -> ignored, single done; rst_n low mid-mul -> all outputs 0 at once, next add completes correctly.
REQ-037 OP_sel=111 -> ERR=1, Result_out=0, Z=1, done after 18 cycles.
